// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl
// Valid/ready FIFO built around an external dual-port RAM. Port A writes,
// port B reads. The RAM has one cycle of read latency, so a two-entry output
// stage (out register plus skid register) keeps the downstream side running
// at one word per cycle. All stream-facing outputs are registered.

module dpram_fifo_ctrl #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,

    // Producer stream
    input  logic [DW-1:0]     s_data,
    input  logic              s_valid,
    output logic              s_ready,

    // Consumer stream
    output logic [DW-1:0]     m_data,
    output logic              m_valid,
    input  logic              m_ready,

    // Total occupancy: RAM + in-flight read + output stage
    output logic [AW+1:0]     count,

    // RAM port A (write side)
    output logic              ram_wren_a,
    output logic [AW-1:0]     ram_addr_a,
    output logic [DW-1:0]     ram_data_a,

    // RAM port B (read side)
    output logic              ram_wren_b,
    output logic [AW-1:0]     ram_addr_b,
    input  logic [DW-1:0]     ram_q_b
);

    // Number of words the RAM can hold; ram_cnt reaching this value means full.
    localparam logic [AW:0] RAM_WORDS = {1'b1, {AW{1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0] wptr_q,     wptr_d;
    logic [AW-1:0] rptr_q,     rptr_d;
    logic [AW:0]   ram_cnt_q,  ram_cnt_d;
    logic          inflight_q, inflight_d;

    // Output stage: out register (drives m_data) and skid register behind it
    logic [DW-1:0] out_q,      out_d;
    logic          out_vld_q,  out_vld_d;
    logic [DW-1:0] skid_q,     skid_d;
    logic          skid_vld_q, skid_vld_d;

    logic          s_ready_q,  s_ready_d;
    logic [AW+1:0] count_q,    count_d;

    // ------------------------------------------------------------------
    // Handshake and read-issue decisions
    // ------------------------------------------------------------------
    logic          push;
    logic          pop;
    logic          issue;
    logic [1:0]    buf_cnt_q;
    logic [1:0]    buf_cnt_d;
    logic [1:0]    stage_load;

    // Reset gates the write strobe so nothing lands in the RAM while rst is high,
    // even before s_ready has been cleared by the first reset edge.
    assign push = s_valid & s_ready_q & ~rst;
    assign pop  = out_vld_q & m_ready;

    assign buf_cnt_q = {1'b0, out_vld_q} + {1'b0, skid_vld_q};
    assign buf_cnt_d = {1'b0, out_vld_d} + {1'b0, skid_vld_d};

    // Words that will occupy the output stage after this cycle's pop, counting
    // the read already in flight. Never exceeds 2, never goes below 0, because
    // a pop requires out_vld_q.
    assign stage_load = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

    // A read is issued only when a slot is guaranteed for the returning word.
    // ram_cnt_q excludes a write happening this cycle, so the address being
    // written is never the one being read.
    assign issue = (ram_cnt_q != '0) && (stage_load < 2'd2);

    // ------------------------------------------------------------------
    // RAM port wiring
    // ------------------------------------------------------------------
    assign ram_wren_a = push;
    assign ram_addr_a = wptr_q;
    assign ram_data_a = s_data;
    assign ram_wren_b = 1'b0;
    assign ram_addr_b = rptr_q;

    // ------------------------------------------------------------------
    // Stream outputs
    // ------------------------------------------------------------------
    assign s_ready = s_ready_q;
    assign m_data  = out_q;
    assign m_valid = out_vld_q;
    assign count   = count_q;

    // Pointer, RAM occupancy and in-flight next-state
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        inflight_d = issue;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (issue) begin
            rptr_d = rptr_q + 1'b1;
        end
        ram_cnt_d = ram_cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue};
    end

    // Output stage next-state: pop shifts skid forward, then the returning RAM
    // word fills the first free slot so order stays strictly FIFO
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;

        if (pop) begin
            out_vld_d  = skid_vld_q;
            skid_vld_d = 1'b0;
            if (skid_vld_q) begin
                out_d = skid_q;
            end
        end

        // stage_load < 2 at issue time guarantees a free slot here
        if (inflight_q) begin
            if (!out_vld_d) begin
                out_d     = ram_q_b;
                out_vld_d = 1'b1;
            end else begin
                skid_d     = ram_q_b;
                skid_vld_d = 1'b1;
            end
        end
    end

    // Registered status: s_ready and count reflect the state after this edge
    always_comb begin
        s_ready_d = (ram_cnt_d < RAM_WORDS);
        count_d   = {1'b0, ram_cnt_d}
                  + {{(AW+1){1'b0}}, inflight_d}
                  + {{AW{1'b0}}, buf_cnt_d};
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            s_ready_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            s_ready_q  <= s_ready_d;
            count_q    <= count_d;
        end
    end

    // Skid data register, qualified entirely by skid_vld_q
    always_ff @(posedge clk) begin
        // NOTE: pure datapath storage is left out of reset; its valid flag is
        // reset, so a stale value is never observed. The RAM itself is not
        // cleared either: pointers reset, so old words are never re-read.
        skid_q <= skid_d;
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl (AW=4, DW=8).
// The RAM is modelled here with OLD_DATA read-during-write behaviour.
// A queue scoreboard holds every accepted word; each pop must match its head,
// and count must always equal the number of words held.

module tb_dpram_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_ready;
    logic [AW+1:0]     count;
    logic              ram_wren_a;
    logic [AW-1:0]     ram_addr_a;
    logic [DW-1:0]     ram_data_a;
    logic              ram_wren_b;
    logic [AW-1:0]     ram_addr_b;
    logic [DW-1:0]     ram_q_b;

    dpram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .count      (count),
        .ram_wren_a (ram_wren_a),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_wren_b (ram_wren_b),
        .ram_addr_b (ram_addr_b),
        .ram_q_b    (ram_q_b)
    );

    always #5 clk = ~clk;

    // Dual-port RAM model: registered read returning the pre-write contents
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wren_a) mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= mem[ram_addr_b];
    end

    logic [DW-1:0] sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            n_pop  = 0;
    logic [DW-1:0] last_pop_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Handshakes are sampled just before the edge, outputs
    // #1 after it; the scoreboard is updated from the observed handshakes.
    task automatic tick();
        bit            do_push;
        bit            do_pop;
        bit            stalled;
        logic [DW-1:0] held;
        do_push = !rst && s_valid && s_ready;
        do_pop  = !rst && m_valid && m_ready;
        stalled = !rst && m_valid && !m_ready;
        held    = m_data;
        if (do_pop) begin
            check("pop_with_data_held", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) check("pop_data", 32'(m_data), 32'(sb.pop_front()));
            n_pop++;
            last_pop_data = m_data;
        end
        if (do_push) sb.push_back(s_data);
        @(posedge clk);
        #1;
        cyc++;
        if (rst) sb.delete();
        check("count", 32'(count), 32'(sb.size()));
        if (stalled && !rst) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", 32'(m_data), 32'(held));
        end
    endtask

    initial begin
        int i;
        int acc;
        int n0;
        int first_cyc;
        int last_cyc;
        int ready_low;

        // ---------------- Reset ----------------
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h33;
        m_ready = 1'b0;
        repeat (3) tick();
        check("rst_wren_a", 32'(ram_wren_a), 32'd0);
        check("rst_wren_b", 32'(ram_wren_b), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        rst     = 1'b0;
        s_valid = 1'b0;
        check("rst_release_s_ready_low", 32'(s_ready), 32'd0);
        tick();
        check("rst_release_s_ready_high", 32'(s_ready), 32'd1);

        // ---------------- Single word latency ----------------
        s_valid = 1'b1;
        s_data  = 8'h5A;
        m_ready = 1'b1;
        tick();                                   // push edge E0
        s_valid = 1'b0;
        check("lat_e0_valid", 32'(m_valid), 32'd0);
        tick();                                   // E1
        check("lat_e1_valid", 32'(m_valid), 32'd0);
        tick();                                   // E2
        check("lat_e2_valid", 32'(m_valid), 32'd1);
        check("lat_e2_data", 32'(m_data), 32'h5A);
        tick();
        check("lat_after_pop_valid", 32'(m_valid), 32'd0);

        // ---------------- Streaming 0..99 ----------------
        n0        = n_pop;
        i         = 0;
        first_cyc = -1;
        last_cyc  = -1;
        ready_low = 0;
        m_ready   = 1'b1;
        for (int k = 0; k < 400 && (n_pop - n0) < 100; k++) begin
            s_valid = (i < 100);
            s_data  = DW'(i);
            acc     = (s_valid && s_ready) ? 1 : 0;
            if (i < 100 && !s_ready) ready_low++;
            if (m_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            tick();
            i += acc;
        end
        s_valid = 1'b0;
        check("stream_pops", 32'(n_pop - n0), 32'd100);
        check("stream_no_gaps", 32'(last_cyc - first_cyc), 32'd99);
        check("stream_ready_drops", 32'(ready_low), 32'd0);

        // ---------------- Fill to full ----------------
        m_ready = 1'b0;
        s_valid = 1'b1;
        acc     = 0;
        for (int k = 0; k < 40; k++) begin
            s_data = DW'(8'hC0 + acc);
            if (s_ready) acc++;
            tick();
        end
        s_valid = 1'b0;
        check("fill_accepted", 32'(acc), 32'(DEPTH + 2));
        check("fill_count", 32'(count), 32'(DEPTH + 2));
        check("fill_s_ready", 32'(s_ready), 32'd0);
        n0      = n_pop;
        m_ready = 1'b1;
        tick();
        check("full_release_s_ready", 32'(s_ready), 32'd1);
        repeat (30) tick();
        check("fill_drain_pops", 32'(n_pop - n0), 32'(DEPTH + 2));

        // ---------------- Random backpressure ----------------
        for (int k = 0; k < 10000; k++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom);
            if (((k / 500) % 2) == 1) m_ready = ($urandom_range(0, 3) == 0);
            else                      m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (40) tick();
        check("random_drained", 32'(count), 32'd0);

        // ---------------- Mid-operation reset ----------------
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_data = DW'(8'h70 + k);
            tick();
        end
        s_valid = 1'b0;
        repeat (4) tick();
        check("midrst_held", 32'(count), 32'd8);
        m_ready = 1'b1;
        tick();                                   // pop; a refill read is now in flight
        m_ready = 1'b0;
        check("midrst_held_inflight", 32'(count), 32'd7);
        rst = 1'b1;
        tick();
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        rst = 1'b0;
        check("midrst_s_ready_low", 32'(s_ready), 32'd0);
        tick();
        check("midrst_s_ready_high", 32'(s_ready), 32'd1);
        n0      = n_pop;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        repeat (6) tick();
        check("midrst_pops", 32'(n_pop - n0), 32'd1);
        check("midrst_data", 32'(last_pop_data), 32'hA5);

        // ---------------- Simultaneous push and pop ----------------
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h11;
        tick();
        s_valid = 1'b0;
        repeat (3) tick();
        check("simul_pre_count", 32'(count), 32'd1);
        n0      = n_pop;
        s_valid = 1'b1;
        s_data  = 8'h22;
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        check("simul_count", 32'(count), 32'd1);
        repeat (5) tick();
        check("simul_pops", 32'(n_pop - n0), 32'd2);
        check("simul_last", 32'(last_pop_data), 32'h22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
